// File: rtl/ccd_timing_pkg.sv
// Shared timing constants and sequencer state encoding for the CCD front end.
// The flag/XV/SUB/HD/VD stage imports the same defaults so hcount ranges agree.
package ccd_timing_pkg;

  localparam int LINE_WD_DEF     = 13;
  localparam int LINE_PERIOD_DEF = 1560;
  localparam int XSG_LINES_DEF   = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_LB = 3'd1;
  localparam logic [2:0] ST_INTEG   = 3'd2;
  localparam logic [2:0] ST_XSG     = 3'd3;
  localparam logic [2:0] ST_READOUT = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WAIT_LB = ST_WAIT_LB,
    INTEG   = ST_INTEG,
    XSG     = ST_XSG,
    READOUT = ST_READOUT
  } seq_state_e;

endpackage

// File: rtl/ccd_line_counter.sv
// Free-running pixel counter; o_lb marks the last pixel of every line.
module ccd_line_counter
  import ccd_timing_pkg::*;
#(
  parameter int LINE_WD     = LINE_WD_DEF,
  parameter int LINE_PERIOD = LINE_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [LINE_WD-1:0] ov_hcount,
  output logic               o_lb
);

  localparam logic [LINE_WD-1:0] H_LAST = LINE_WD'(LINE_PERIOD - 1);

  assign o_lb = (ov_hcount == H_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ov_hcount <= '0;
    else if (o_lb) ov_hcount <= '0;
    else           ov_hcount <= ov_hcount + 1'b1;
  end

endmodule

// File: rtl/ccd_frame_sequencer.sv
// Frame sequencer: integration -> XSG transfer -> readout, advancing only on
// line boundaries so downstream per-line waveforms are never truncated.
module ccd_frame_sequencer
  import ccd_timing_pkg::*;
#(
  parameter int LINE_WD     = LINE_WD_DEF,
  parameter int LINE_PERIOD = LINE_PERIOD_DEF,
  parameter int XSG_LINES   = XSG_LINES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic               i_trigger_mode,
  input  logic               i_trigger,
  input  logic [LINE_WD-1:0] iv_exposure_lines,
  input  logic [LINE_WD-1:0] iv_readout_lines,
  output logic [LINE_WD-1:0] ov_hcount,
  output logic [LINE_WD-1:0] ov_vcount,
  output logic               o_integration,
  output logic               o_xsg_flag,
  output logic               o_readout_flag,
  output logic               o_frame_done,
  output logic               o_trigger_drop
);

  localparam logic [LINE_WD-1:0] XSG_LAST = LINE_WD'(XSG_LINES - 1);

  seq_state_e         state;
  logic [LINE_WD-1:0] vcount;
  logic [LINE_WD-1:0] shadow_exp;
  logic [LINE_WD-1:0] shadow_ro;
  logic               lb;
  logic               trig_ev;
  logic               start_ev;

  ccd_line_counter #(
    .LINE_WD    (LINE_WD),
    .LINE_PERIOD(LINE_PERIOD)
  ) u_line (
    .clk      (clk),
    .reset    (reset),
    .ov_hcount(ov_hcount),
    .o_lb     (lb)
  );

  assign trig_ev   = i_trigger_mode & i_trigger;
  assign start_ev  = i_enable & (~i_trigger_mode | i_trigger);
  assign ov_vcount = vcount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      vcount         <= '0;
      shadow_exp     <= '0;
      shadow_ro      <= '0;
      o_integration  <= 1'b0;
      o_xsg_flag     <= 1'b0;
      o_readout_flag <= 1'b0;
      o_frame_done   <= 1'b0;
      o_trigger_drop <= 1'b0;
    end else begin
      o_frame_done   <= 1'b0;
      // Triggers arriving mid-frame are dropped, never queued.
      o_trigger_drop <= trig_ev && (state != IDLE);
      case (state)
        IDLE: begin
          vcount <= '0;
          if (start_ev) begin
            state      <= WAIT_LB;
            shadow_exp <= (iv_exposure_lines == '0) ? LINE_WD'(1) : iv_exposure_lines;
            shadow_ro  <= (iv_readout_lines  == '0) ? LINE_WD'(1) : iv_readout_lines;
          end
        end
        WAIT_LB: begin
          if (lb) begin
            vcount <= '0;
            if (!i_enable) begin
              state <= IDLE;
            end else begin
              state         <= INTEG;
              o_integration <= 1'b1;
            end
          end
        end
        INTEG: begin
          if (lb) begin
            if (!i_enable) begin
              state         <= IDLE;
              vcount        <= '0;
              o_integration <= 1'b0;
            end else if (vcount == shadow_exp - 1'b1) begin
              state         <= XSG;
              vcount        <= '0;
              o_integration <= 1'b0;
              o_xsg_flag    <= 1'b1;
            end else begin
              vcount <= vcount + 1'b1;
            end
          end
        end
        // Once charge is transferred the frame must finish regardless of enable.
        XSG: begin
          if (lb) begin
            if (vcount == XSG_LAST) begin
              state          <= READOUT;
              vcount         <= '0;
              o_xsg_flag     <= 1'b0;
              o_readout_flag <= 1'b1;
            end else begin
              vcount <= vcount + 1'b1;
            end
          end
        end
        READOUT: begin
          if (lb) begin
            if (vcount == shadow_ro - 1'b1) begin
              state          <= IDLE;
              vcount         <= '0;
              o_readout_flag <= 1'b0;
              o_frame_done   <= 1'b1;
            end else begin
              vcount <= vcount + 1'b1;
            end
          end
        end
        default: begin
          state          <= IDLE;
          vcount         <= '0;
          o_integration  <= 1'b0;
          o_xsg_flag     <= 1'b0;
          o_readout_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// Scoreboard bench for ccd_frame_sequencer with a short line (LINE_PERIOD=20).
// Stimulus pushes expected output events; a monitor pops them as they appear.
module tb_ccd_frame_sequencer;
  localparam int LW = 13;
  localparam int LP = 20;
  localparam int XL = 2;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_INT  = 3'b100;
  localparam logic [2:0] F_XSG  = 3'b010;
  localparam logic [2:0] F_RO   = 3'b001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_trigger_mode = 1'b0;
  logic          i_trigger = 1'b0;
  logic [LW-1:0] iv_exposure_lines = '0;
  logic [LW-1:0] iv_readout_lines = '0;
  logic [LW-1:0] ov_hcount;
  logic [LW-1:0] ov_vcount;
  logic          o_integration;
  logic          o_xsg_flag;
  logic          o_readout_flag;
  logic          o_frame_done;
  logic          o_trigger_drop;

  ccd_frame_sequencer #(
    .LINE_WD    (LW),
    .LINE_PERIOD(LP),
    .XSG_LINES  (XL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_enable         (i_enable),
    .i_trigger_mode   (i_trigger_mode),
    .i_trigger        (i_trigger),
    .iv_exposure_lines(iv_exposure_lines),
    .iv_readout_lines (iv_readout_lines),
    .ov_hcount        (ov_hcount),
    .ov_vcount        (ov_vcount),
    .o_integration    (o_integration),
    .o_xsg_flag       (o_xsg_flag),
    .o_readout_flag   (o_readout_flag),
    .o_frame_done     (o_frame_done),
    .o_trigger_drop   (o_trigger_drop)
  );

  always #5 clk = ~clk;

  // One event = any change of {flags, vcount}, or a done/drop pulse.
  // dt = clocks since the previous event or since a stimulus anchor
  // (trigger pulse or enable rise, as sampled by the DUT).
  typedef struct {
    logic [2:0]    fl;
    logic          done;
    logic          drop;
    logic [LW-1:0] vc;
    int            dt;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  task automatic push(input logic [2:0] fl, input logic done, input logic drop,
                      input int vc, input int dt);
    ev_t e;
    e.fl = fl; e.done = done; e.drop = drop; e.vc = LW'(vc); e.dt = dt;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int exp_l, input int ro_l, input int first_dt);
    push(F_INT, 1'b0, 1'b0, 0, first_dt);
    for (int v = 1; v < exp_l; v++) push(F_INT, 1'b0, 1'b0, v, LP);
    for (int v = 0; v < XL; v++)    push(F_XSG, 1'b0, 1'b0, v, LP);
    for (int v = 0; v < ro_l; v++)  push(F_RO, 1'b0, 1'b0, v, LP);
    push(F_NONE, 1'b1, 1'b0, 0, LP);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Monitor / scoreboard
  logic [LW+2:0] prev_st = '0;
  logic          prev_en = 1'b0;
  int            last_ev = 0;

  always begin
    logic [LW+2:0] cur;
    ev_t           e;
    ev_t           x;
    @(posedge clk);
    cyc++;
    #2;
    if (reset) begin
      prev_st = '0;
      prev_en = i_enable;
      last_ev = cyc;
    end else begin
      if ((i_trigger_mode && i_trigger) || (i_enable && !prev_en)) last_ev = cyc;
      prev_en = i_enable;
      cur = {o_integration, o_xsg_flag, o_readout_flag, ov_vcount};
      if (cur != prev_st || o_frame_done || o_trigger_drop) begin
        e.fl   = {o_integration, o_xsg_flag, o_readout_flag};
        e.done = o_frame_done;
        e.drop = o_trigger_drop;
        e.vc   = ov_vcount;
        e.dt   = cyc - last_ev;
        last_ev = cyc;
        prev_st = cur;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got fl=%b done=%b drop=%b vc=%0d dt=%0d want none",
                   e.fl, e.done, e.drop, e.vc, e.dt);
        end else begin
          x = sb.pop_front();
          if (e.fl !== x.fl || e.done !== x.done || e.drop !== x.drop ||
              e.vc !== x.vc || e.dt != x.dt) begin
            bad++;
            $display("FAIL event: got fl=%b done=%b drop=%b vc=%0d dt=%0d want fl=%b done=%b drop=%b vc=%0d dt=%0d",
                     e.fl, e.done, e.drop, e.vc, e.dt, x.fl, x.done, x.drop, x.vc, x.dt);
          end
        end
      end
    end
  end

  task automatic wait_hc(input int h);
    int n = 0;
    while (ov_hcount != LW'(h) && n < LP + 2) begin @(negedge clk); n++; end
    if (ov_hcount != LW'(h)) tmo("wait_hcount");
  endtask

  function automatic bit cond(input int which, input int vc, input int hc);
    logic f;
    case (which)
      0:       f = o_integration;
      1:       f = o_xsg_flag;
      2:       f = o_readout_flag;
      default: f = o_frame_done;
    endcase
    return f && (vc < 0 || ov_vcount == LW'(vc)) && (hc < 0 || ov_hcount == LW'(hc));
  endfunction

  task automatic wait_flag(input int which, input int vc, input int hc, input int maxc,
                           input string nm);
    int n = 0;
    while (!cond(which, vc, hc) && n < maxc) begin @(negedge clk); n++; end
    if (!cond(which, vc, hc)) tmo(nm);
  endtask

  task automatic wait_q_empty(input int maxc, input string nm);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      tmo(nm);
      sb.delete();
    end
  endtask

  task automatic pulse_trigger();
    i_trigger = 1'b1;
    @(negedge clk);
    i_trigger = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_hcount"}, 32'(ov_hcount), 32'd0);
    chk({nm, "_vcount"}, 32'(ov_vcount), 32'd0);
    chk({nm, "_flags"},
        32'({o_integration, o_xsg_flag, o_readout_flag, o_frame_done, o_trigger_drop}), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and hcount wrap 19 -> 0
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    for (int k = 0; k < LP + 5; k++) begin
      chk("hcount_walk", 32'(ov_hcount), 32'(k % LP));
      @(negedge clk);
    end

    // Triggered frame: exp=3, ro=4, trigger at hcount=5
    i_trigger_mode = 1'b1; i_enable = 1'b1;
    iv_exposure_lines = 13'd3; iv_readout_lines = 13'd4;
    push_frame(3, 4, LP - 6);
    wait_hc(5);
    pulse_trigger();
    wait_q_empty(20 * LP, "trig_frame");
    repeat (3 * LP) @(negedge clk);

    // Zero lengths clamp to one line each
    iv_exposure_lines = 13'd0; iv_readout_lines = 13'd0;
    push_frame(1, 1, LP - 6);
    wait_hc(5);
    pulse_trigger();
    wait_q_empty(10 * LP, "zero_len");
    repeat (2 * LP) @(negedge clk);

    // Trigger during READOUT is dropped, no second frame
    iv_exposure_lines = 13'd1; iv_readout_lines = 13'd3;
    push(F_INT, 1'b0, 1'b0, 0, LP - 6);
    push(F_XSG, 1'b0, 1'b0, 0, LP);
    push(F_XSG, 1'b0, 1'b0, 1, LP);
    push(F_RO,  1'b0, 1'b0, 0, LP);
    push(F_RO,  1'b0, 1'b0, 1, LP);
    push(F_RO,  1'b0, 1'b1, 1, 0);
    push(F_RO,  1'b0, 1'b0, 2, LP - 6);
    push(F_NONE, 1'b1, 1'b0, 0, LP);
    wait_hc(5);
    pulse_trigger();
    wait_flag(2, 1, 5, 10 * LP, "ro_v1");
    pulse_trigger();
    wait_q_empty(10 * LP, "trig_drop");
    repeat (3 * LP) @(negedge clk);

    // Free-run back-to-back; exposure change applies to the next frame;
    // enable dropped in READOUT of frame 2 still completes it
    i_enable = 1'b0; i_trigger_mode = 1'b0;
    iv_exposure_lines = 13'd2; iv_readout_lines = 13'd2;
    @(negedge clk);
    push_frame(2, 2, LP - 6);
    push_frame(3, 2, LP);
    wait_hc(5);
    i_enable = 1'b1;
    wait_flag(0, -1, -1, 3 * LP, "fr_integ");
    iv_exposure_lines = 13'd3;
    wait_flag(3, -1, -1, 10 * LP, "fr_done1");
    @(negedge clk);
    wait_flag(2, -1, -1, 10 * LP, "fr_ro2");
    i_enable = 1'b0;
    wait_q_empty(10 * LP, "free_run");
    repeat (3 * LP) @(negedge clk);

    // Enable dropped in INTEG at vcount=1 aborts at next lb, no done
    i_trigger_mode = 1'b1; i_enable = 1'b1;
    iv_exposure_lines = 13'd5; iv_readout_lines = 13'd2;
    push(F_INT,  1'b0, 1'b0, 0, LP - 6);
    push(F_INT,  1'b0, 1'b0, 1, LP);
    push(F_NONE, 1'b0, 1'b0, 0, LP);
    wait_hc(5);
    pulse_trigger();
    wait_flag(0, 1, -1, 3 * LP, "ab_v1");
    i_enable = 1'b0;
    wait_q_empty(3 * LP, "abort");
    repeat (3 * LP) @(negedge clk);

    // Reset mid-frame (XSG, hcount=7) clears everything at once
    i_enable = 1'b1;
    iv_exposure_lines = 13'd2; iv_readout_lines = 13'd2;
    push(F_INT, 1'b0, 1'b0, 0, LP - 6);
    push(F_INT, 1'b0, 1'b0, 1, LP);
    push(F_XSG, 1'b0, 1'b0, 0, LP);
    wait_hc(5);
    pulse_trigger();
    wait_flag(1, 0, 7, 5 * LP, "rst_xsg");
    reset = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_queue", 32'(sb.size()), 32'd0);
    for (int k = 0; k < LP + 3; k++) begin
      chk("hcount_after_reset", 32'(ov_hcount), 32'(k % LP));
      @(negedge clk);
    end
    repeat (2 * LP) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccd_frame_sequencer.md
Name: ccd_frame_sequencer

Overview:
- Upstream timing master for the CCD front end: generates the free-running line counter, the per-phase line counter and the frame phase flags.
- The flag/XV/SUB/HD/VD generator stage directly downstream consumes these outputs.
- Sequences each frame through integration, XSG transfer and readout, from either a trigger or free-run mode.
- All phase changes occur only on line boundaries, so downstream per-line waveforms are never truncated.

Parameters:
- LINE_WD, 13, width of the line and pixel counters.
- LINE_PERIOD, 1560, clocks per line; hcount range is 0..LINE_PERIOD-1.
- XSG_LINES, 2, number of lines spent in the XSG transfer phase.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  sequencer enable.
- i_trigger_mode  in  1  0 = free-run, 1 = triggered.
- i_trigger  in  1  single-cycle trigger pulse; used only when i_trigger_mode=1.
- iv_exposure_lines  in  LINE_WD  integration length in lines.
- iv_readout_lines  in  LINE_WD  readout length in lines.
- ov_hcount  out  LINE_WD  pixel position within the current line.
- ov_vcount  out  LINE_WD  line index within the current phase.
- o_integration  out  1  high during the INTEG phase.
- o_xsg_flag  out  1  high during the XSG phase.
- o_readout_flag  out  1  high during the READOUT phase.
- o_frame_done  out  1  one-clock pulse at the end of readout.
- o_trigger_drop  out  1  one-clock pulse when a trigger is ignored.

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, shadow registers 0.
- hcount:
  - Free-runs 0..LINE_PERIOD-1 and wraps to 0 in every state.
  - Forced to 0 only by reset.
- Line boundary (lb) = hcount==LINE_PERIOD-1.
- States: IDLE, WAIT_LB, INTEG, XSG, READOUT.
- IDLE → WAIT_LB on a start event, which is either:
  - i_enable && i_trigger_mode=0, or
  - i_enable && i_trigger_mode=1 && i_trigger.
- Shadow latching at the start event:
  - shadow_exp = max(iv_exposure_lines, 1).
  - shadow_ro = max(iv_readout_lines, 1).
  - Input changes after latching have no effect until the next frame.
- WAIT_LB → INTEG on lb; vcount is cleared to 0.
- INTEG:
  - vcount increments on each lb.
  - On lb with vcount==shadow_exp-1 → XSG, vcount=0.
- XSG:
  - On lb with vcount==XSG_LINES-1 → READOUT, vcount=0; otherwise vcount increments.
- READOUT:
  - On lb with vcount==shadow_ro-1 → IDLE, vcount=0, o_frame_done=1 for that one clock.
  - Otherwise vcount increments.
- Free-run back-to-back: when a frame ends with free-run and i_enable still high, the IDLE→WAIT_LB→INTEG path applies with no extra line gap, since IDLE re-evaluates on the next clock. Net gap is therefore one full line.
- Phase flags are registered state decodes. They change in the same clock edge as the vcount reset, one cycle after lb.
- vcount is held at 0 in IDLE and WAIT_LB.
- o_trigger_drop pulses for one clock when i_trigger=1 in triggered mode while state != IDLE. That trigger is discarded, not queued.
- i_enable deasserted:
  - In WAIT_LB or INTEG: abort to IDLE at the next lb, with no frame_done.
  - In XSG or READOUT: the frame completes normally.
- Mode change mid-frame is sampled only in IDLE.
- Reset mid-frame returns to IDLE immediately; there is no partial-frame recovery.
- vcount never exceeds max(shadow_exp, XSG_LINES, shadow_ro)-1, so no wrap occurs at LINE_WD.

Decomposition:
- Shared package ccd_timing_pkg holds:
  - State encoding localparams (IDLE=0 … READOUT=4).
  - LINE_WD and LINE_PERIOD defaults, shared with the flag stage so hcount ranges agree.
- Natural sub-module: ccd_line_counter, which implements the hcount wrap and lb generation.
- The FSM, shadow registers and vcount stay in the top module.

Test Plan:
- Reset:
  - Stimulus: LINE_PERIOD=20, reset pulse mid-line.
  - Required: all outputs 0 immediately; hcount restarts at 0 and wraps 19→0.
- Triggered frame:
  - Stimulus: LINE_PERIOD=20, mode=1, exp=3, ro=4, trigger at hcount=5.
  - Required: integration high 3 lines (60 clks) from the first lb, xsg 2 lines, readout 4 lines with vcount 0..3, frame_done once, then IDLE.
- Zero lengths:
  - Stimulus: exp=0, ro=0.
  - Required: integration lasts exactly 1 line and readout exactly 1 line.
- Trigger during a frame:
  - Stimulus: second trigger during READOUT.
  - Required: o_trigger_drop pulses 1 clk; no second frame starts.
- Free-run:
  - Stimulus: mode=0, enable held, exp=2, ro=2.
  - Required: consecutive frames separated by exactly 1 line; iv_exposure_lines changed mid-frame takes effect only on the following frame.
- Enable deassert:
  - Stimulus: enable dropped in INTEG at vcount=1 (exp=5).
  - Required: return to IDLE at the next lb, no frame_done.
  - Stimulus: enable dropped in READOUT.
  - Required: the frame completes and frame_done asserts.
